// File: rtl/ddma_mmio_pkg.sv
// Shared constants for the ddma CPU register block: register offsets, send
// FSM encoding, interrupt bit positions and CTRL command bits.
package ddma_mmio_pkg;

  localparam int unsigned OFF_SEND_ADDR = 'h00;
  localparam int unsigned OFF_SEND_SIZE = 'h04;
  localparam int unsigned OFF_SEND_DEST = 'h08;
  localparam int unsigned OFF_CTRL      = 'h0C;
  localparam int unsigned OFF_RECV_ADDR = 'h10;
  localparam int unsigned OFF_RECV_SIZE = 'h14;
  localparam int unsigned OFF_STATUS    = 'h18;
  localparam int unsigned OFF_IRQ_MASK  = 'h1C;
  localparam int unsigned OFF_IRQ_PEND  = 'h20;

  localparam int unsigned IRQ_SEND      = 0;
  localparam int unsigned IRQ_RECV_SIZE = 1;
  localparam int unsigned IRQ_RECV_HSHK = 2;
  localparam int unsigned IRQ_COUNT     = 3;

  localparam int unsigned CTRL_SEND     = 0;
  localparam int unsigned CTRL_RECV_ACK = 1;
  localparam int unsigned CTRL_ERR_CLR  = 2;

  localparam int unsigned STATUS_ERR    = 24;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } send_state_t;

endpackage

// File: rtl/ddma_irq_latch.sv
// Rising-edge detector feeding a write-1-to-clear pending bit; a new edge
// in the same cycle as a clear keeps the bit set.
module ddma_irq_latch #(
  parameter bit PEND_RESET = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic irq_in,
  input  logic clear,
  output logic pend
);

  logic irq_prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      irq_prev <= 1'b0;
      pend     <= PEND_RESET;
    end else begin
      irq_prev <= irq_in;
      pend     <= (irq_in & ~irq_prev) | (pend & ~clear);
    end
  end

endmodule

// File: rtl/ddma_mmio_ctrl.sv
// CPU register block in front of the double DMA: config registers, send
// command handshake, receive-ack toggle and maskable interrupt pending.
module ddma_mmio_ctrl
  import ddma_mmio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bus_en_in,
  input  logic                  bus_we_in,
  input  logic [ADDR_WIDTH-1:0] bus_addr_in,
  input  logic [DATA_WIDTH-1:0] bus_wdata_in,
  output logic [DATA_WIDTH-1:0] bus_rdata_out,
  output logic                  bus_ready_out,
  output logic                  send_cmd_out,
  output logic [DATA_WIDTH-1:0] send_addr_out,
  output logic [DATA_WIDTH-1:0] send_size_out,
  output logic [DATA_WIDTH-1:0] send_dest_out,
  output logic                  recv_cmd_out,
  output logic [DATA_WIDTH-1:0] recv_addr_out,
  input  logic [DATA_WIDTH-1:0] recv_size_in,
  input  logic [2:0]            state_send_in,
  input  logic [2:0]            state_recv_in,
  input  logic                  irq_send_in,
  input  logic                  irq_recv_size_in,
  input  logic                  irq_recv_hshk_in,
  output logic                  irq_out
);

  send_state_t           state, state_next;
  logic                  send_cmd_next;
  logic                  err, err_set, err_clr;
  logic [IRQ_COUNT-1:0]  irq_mask, irq_pend, irq_levels, pend_clear;
  logic [DATA_WIDTH-1:0] read_value, status;
  logic                  wr, ctrl_wr, pend_wr, cfg_wr, recv_toggle;

  assign wr          = bus_en_in & bus_we_in;
  assign ctrl_wr     = wr && (bus_addr_in == ADDR_WIDTH'(OFF_CTRL));
  assign pend_wr     = wr && (bus_addr_in == ADDR_WIDTH'(OFF_IRQ_PEND));
  assign cfg_wr      = wr && ((bus_addr_in == ADDR_WIDTH'(OFF_SEND_ADDR)) ||
                              (bus_addr_in == ADDR_WIDTH'(OFF_SEND_SIZE)) ||
                              (bus_addr_in == ADDR_WIDTH'(OFF_SEND_DEST)));
  assign recv_toggle = ctrl_wr && bus_wdata_in[CTRL_RECV_ACK] &&
                       (irq_recv_size_in || irq_recv_hshk_in);
  assign err_clr     = ctrl_wr && bus_wdata_in[CTRL_ERR_CLR];
  assign irq_levels  = {irq_recv_hshk_in, irq_recv_size_in, irq_send_in};
  assign pend_clear  = pend_wr ? bus_wdata_in[IRQ_COUNT-1:0] : '0;

  for (genvar i = 0; i < IRQ_COUNT; i++) begin : g_irq
    ddma_irq_latch u_latch (
      .clock  (clock),
      .reset  (reset),
      .irq_in (irq_levels[i]),
      .clear  (pend_clear[i]),
      .pend   (irq_pend[i])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    unique case (state)
      S_IDLE:    if (ctrl_wr && bus_wdata_in[CTRL_SEND] && state_send_in == 3'd0)
                   state_next = S_BUSY;
      S_BUSY:    if (irq_send_in) state_next = S_DONE;
      S_DONE:    if (pend_wr && bus_wdata_in[IRQ_SEND]) state_next = S_RELEASE;
      S_RELEASE: if (!irq_send_in) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    // Rejected commands and config writes during a transfer only flag ERR.
    if (ctrl_wr && bus_wdata_in[CTRL_SEND] && (state != S_IDLE || state_send_in != 3'd0))
      err_set = 1'b1;
    if (ctrl_wr && bus_wdata_in[CTRL_RECV_ACK] && !(irq_recv_size_in || irq_recv_hshk_in))
      err_set = 1'b1;
    if (cfg_wr && state != S_IDLE)
      err_set = 1'b1;
    send_cmd_next = (state_next == S_BUSY) || (state_next == S_DONE);
  end

  always_comb begin
    status                 = '0;
    status[2:0]            = state_send_in;
    status[10:8]           = state_recv_in;
    status[17:16]          = state;
    status[STATUS_ERR]     = err;
    read_value             = '0;
    case (bus_addr_in)
      ADDR_WIDTH'(OFF_SEND_ADDR): read_value = send_addr_out;
      ADDR_WIDTH'(OFF_SEND_SIZE): read_value = send_size_out;
      ADDR_WIDTH'(OFF_SEND_DEST): read_value = send_dest_out;
      ADDR_WIDTH'(OFF_RECV_ADDR): read_value = recv_addr_out;
      ADDR_WIDTH'(OFF_RECV_SIZE): read_value = recv_size_in;
      ADDR_WIDTH'(OFF_STATUS):    read_value = status;
      ADDR_WIDTH'(OFF_IRQ_MASK):  read_value = DATA_WIDTH'(irq_mask);
      ADDR_WIDTH'(OFF_IRQ_PEND):  read_value = DATA_WIDTH'(irq_pend);
      default:                    read_value = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bus_rdata_out <= '0;
      bus_ready_out <= 1'b0;
      send_cmd_out  <= 1'b0;
      send_addr_out <= '0;
      send_size_out <= '0;
      send_dest_out <= '0;
      recv_cmd_out  <= 1'b0;
      recv_addr_out <= '0;
      irq_mask      <= '0;
      err           <= 1'b0;
      irq_out       <= 1'b0;
    end else begin
      bus_ready_out <= bus_en_in;
      if (bus_en_in && !bus_we_in) bus_rdata_out <= read_value;
      send_cmd_out  <= send_cmd_next;
      err           <= (err & ~err_clr) | err_set;
      irq_out       <= |(irq_pend & irq_mask);
      if (recv_toggle) recv_cmd_out <= ~recv_cmd_out;
      if (cfg_wr && state == S_IDLE) begin
        if (bus_addr_in == ADDR_WIDTH'(OFF_SEND_ADDR)) send_addr_out <= bus_wdata_in;
        if (bus_addr_in == ADDR_WIDTH'(OFF_SEND_SIZE)) send_size_out <= bus_wdata_in;
        if (bus_addr_in == ADDR_WIDTH'(OFF_SEND_DEST)) send_dest_out <= bus_wdata_in;
      end
      if (wr && bus_addr_in == ADDR_WIDTH'(OFF_RECV_ADDR)) recv_addr_out <= bus_wdata_in;
      if (wr && bus_addr_in == ADDR_WIDTH'(OFF_IRQ_MASK))  irq_mask <= bus_wdata_in[IRQ_COUNT-1:0];
    end
  end

endmodule

// File: doc/ddma_mmio_ctrl.md
# ddma_mmio_ctrl

CPU-facing control/status register block sitting directly upstream of the double DMA (ddma). Decodes word-addressed CPU bus accesses into the ddma configuration and command signals, runs the send-command handshake and receive-acknowledge toggles on the CPU's behalf, and latches the three ddma interrupt levels into a maskable pending register driving a single CPU interrupt line.

## Interface
- DATA_WIDTH, 32, bus data width and ddma configuration register width
- ADDR_WIDTH, 8, bus offset width; byte offsets, word aligned
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- bus_en_in  in  1  access strobe, one cycle per access
- bus_we_in  in  1  1 = write, 0 = read
- bus_addr_in  in  ADDR_WIDTH  byte offset
- bus_wdata_in  in  DATA_WIDTH  write data
- bus_rdata_out  out  DATA_WIDTH  read data, valid with bus_ready_out
- bus_ready_out  out  1  access-complete pulse
- send_cmd_out, send_addr_out, send_size_out, send_dest_out  out  1/DATA_WIDTH×3  ddma send command and configuration
- recv_cmd_out  out  1  ddma receive acknowledge; toggled, not pulsed
- recv_addr_out  out  DATA_WIDTH  ddma receive buffer address
- recv_size_in  in  DATA_WIDTH  payload size reported by ddma
- state_send_in, state_recv_in  in  3  ddma FSM states, 0 = idle
- irq_send_in, irq_recv_size_in, irq_recv_hshk_in  in  1  ddma interrupt levels
- irq_out  out  1  CPU interrupt

## Operation
- Register map: 0x00 SEND_ADDR (RW), 0x04 SEND_SIZE (RW), 0x08 SEND_DEST (RW), 0x0C CTRL (WO, reads 0), 0x10 RECV_ADDR (RW), 0x14 RECV_SIZE (RO, recv_size_in), 0x18 STATUS (RO), 0x1C IRQ_MASK (RW, bits[2:0]), 0x20 IRQ_PEND (W1C, bits[2:0]). Unmapped offsets read 0; writes to them or to RO registers are ignored but still complete.
- STATUS: [2:0] state_send_in, [10:8] state_recv_in, [17:16] send FSM state, [24] sticky ERR (cleared by writing CTRL bit2).
- IRQ_PEND bits: 0 = send done, 1 = recv size, 2 = recv handshake. Each set on the rising edge of its ddma irq input (previous-cycle register). irq_out = |(IRQ_PEND & IRQ_MASK), registered.
- Send FSM (2-bit): S_IDLE -> S_BUSY on CTRL bit0 write when state_send_in == 0 (send_cmd_out <= 1). S_BUSY -> S_DONE when irq_send_in == 1. S_DONE -> S_RELEASE when IRQ_PEND bit0 cleared by CPU (send_cmd_out <= 0). S_RELEASE -> S_IDLE when irq_send_in == 0. CTRL bit0 outside S_IDLE, or while state_send_in != 0, sets ERR and is otherwise ignored.
- SEND_ADDR/SIZE/DEST writes are ignored outside S_IDLE (set ERR); outputs stay stable for the whole transfer.
- Receive ack: CTRL bit1 write toggles recv_cmd_out only when irq_recv_size_in or irq_recv_hshk_in is high; otherwise sets ERR. RECV_ADDR must be written before ack of recv size; it is forwarded continuously.
- Simultaneous pending set (edge) and W1C clear on the same bit: set wins.

## Timing
- Reset: all registers 0, send FSM S_IDLE, send_cmd_out=0, recv_cmd_out=0, irq_out=0, bus_ready_out=0, bus_rdata_out=0, ERR=0, irq edge registers 0.
- Every access completes in exactly one cycle: bus_ready_out pulses the cycle after bus_en_in; read data is sampled at the strobe cycle and held until the next access.
- Register writes take effect on the clock edge ending the strobe cycle; send_cmd_out/recv_cmd_out change on that same edge.
- Pending bit set one cycle after irq input rises; irq_out follows pending/mask one cycle later (2-cycle irq latency).
- Reset asserted mid-transfer: send_cmd_out drops on the reset edge; ddma is reset by the same line, so no release handshake is performed.

## Structure
- Package ddma_mmio_pkg: register offset constants, send FSM typedef (S_IDLE, S_BUSY, S_DONE, S_RELEASE), IRQ bit index constants, CTRL bit indices.
- One sub-module ddma_irq_latch: parameterised edge detector + pending bit with W1C and set-wins priority, instantiated three times.

## Test plan
- Reset then read all offsets -> every register reads 0, irq_out=0, bus_ready_out pulses one cycle after each strobe.
- Write SEND_ADDR=0x100, SIZE=4, DEST=0x11, CTRL=1 -> send_cmd_out=1 next cycle; model raises irq_send_in -> PEND=0x1, with MASK=0x1 irq_out=1 two cycles later; W1C 0x1 -> send_cmd_out=0; irq_send_in falls -> FSM S_IDLE.
- CTRL=1 while S_BUSY, and SEND_SIZE write while S_BUSY -> no change to outputs, STATUS[24]=1; CTRL=4 -> ERR cleared.
- irq_recv_size_in rises with recv_size_in=8 -> PEND bit1, RECV_SIZE reads 8; write RECV_ADDR=0x200, CTRL=2 -> recv_cmd_out 0->1; irq_recv_hshk_in, CTRL=2 -> recv_cmd_out 1->0; CTRL=2 with no irq -> no toggle, ERR=1.
- irq edge and W1C of same bit in same cycle -> bit remains 1.
- Reset asserted in S_BUSY -> send_cmd_out=0, FSM S_IDLE, PEND=0 next cycle.
